// File: rtl/hex_scan.sv
// Multiplexed hex display scanner. A shadow register feeds the display and
// changes only at frame boundaries, so a single frame never mixes old and new digits.
module hex_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  frame,
  output logic                  pend
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_q, pend_d;
  logic [3:0]          nibble_q, nibble_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;
  logic                tick, boundary, lead_zero, show;

  always_comb begin
    tick     = (cnt_q == CW'(DIV - 1));
    boundary = tick && (idx_q == IW'(DIGITS - 1));

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    // A load exactly on the boundary bypasses the pending slot.
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (boundary) begin
      pend_d = 1'b0;
      if (load)        shadow_d = value;
      else if (pend_q) shadow_d = pending_q;
    end else if (load) begin
      pending_d = value;
      pend_d    = 1'b1;
    end

    frame_d = boundary;

    // Outputs are precomputed from next-cycle state so they line up with cnt/idx.
    nibble_d  = 4'h0;
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) >= idx_d && shadow_d[4*i +: 4] != 4'h0) lead_zero = 1'b0;
      if (idx_d == IW'(i)) nibble_d = shadow_d[4*i +: 4];
    end
    show = (cnt_d >= CW'(BLANK)) && !(blank_lz && (idx_d != '0) && lead_zero);
    an_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (show && idx_d == IW'(i)) an_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      nibble_q  <= 4'h0;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      nibble_q  <= nibble_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign nibble = nibble_q;
  assign an     = an_q;
  assign frame  = frame_q;
  assign pend   = pend_q;

endmodule

// File: tb/tb_hex_scan.sv
// Self-checking bench for hex_scan (DIGITS=4, DIV=4, BLANK=1): directed scenarios
// plus random traffic, all compared against a cycle-count based reference model.
module tb_hex_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BLANK  = 1;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        frame;
  logic        pend;

  int checks   = 0;
  int failures = 0;

  // Reference model: t counts cycles since reset release.
  int          t;
  logic [15:0] m_shadow;
  logic [15:0] m_pending;
  logic        m_pend;
  logic        m_prev_blz;
  int          act[DIGITS];
  logic        seen;
  logic        blz_r;

  hex_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .nibble   (nibble),
    .an       (an),
    .frame    (frame),
    .pend     (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    t          = 0;
    m_shadow   = 16'h0;
    m_pending  = 16'h0;
    m_pend     = 1'b0;
    m_prev_blz = 1'b0;
  endtask

  // One clock: apply inputs, advance the model at the edge, check #1 later.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic blz);
    int   cnt;
    int   idx;
    logic [3:0] ean;
    load     = ld;
    value    = v;
    blank_lz = blz;
    @(posedge clk);
    if (t % FRAME == FRAME - 1) begin
      if (ld)          m_shadow = v;
      else if (m_pend) m_shadow = m_pending;
      m_pend = 1'b0;
    end else if (ld) begin
      m_pending = v;
      m_pend    = 1'b1;
    end
    m_prev_blz = blz;
    t++;
    #1;
    cnt = t % DIV;
    idx = (t / DIV) % DIGITS;
    ean = 4'hF;
    if (cnt >= BLANK && !(m_prev_blz && idx != 0 && (m_shadow >> (4 * idx)) == 16'h0))
      ean = ~(4'b0001 << idx);
    chk("an", an, ean);
    chk("nibble", nibble, (m_shadow >> (4 * idx)) & 16'hF);
    chk("frame", frame, (t % FRAME) == 0);
    chk("pend", pend, m_pend);
    chk("an_onehot", $countones(~an) <= 1, 1);
  endtask

  task automatic run_to(input int phase, input logic blz);
    while (t % FRAME != phase) cycle(1'b0, 16'h0, blz);
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_nibble", nibble, 4'h0);
    chk("rst_frame", frame, 1'b0);
    chk("rst_pend", pend, 1'b0);
    rst = 1'b0;
    model_reset();

    // Single load of 1234; second frame shows 4,3,2,1 each lit 3 of 4 cycles.
    cycle(1'b1, 16'h1234, 1'b0);
    chk("pend_1234", pend, 1'b1);
    run_to(0, 1'b0);
    for (int d = 0; d < DIGITS; d++) act[d] = 0;
    for (int c = 0; c < FRAME; c++) begin
      cycle(1'b0, 16'h0, 1'b0);
      for (int d = 0; d < DIGITS; d++) if (an[d] == 1'b0) act[d]++;
    end
    for (int d = 0; d < DIGITS; d++) chk("active_cycles", act[d], DIV - BLANK);

    // ABCD then 5678 before the boundary: last one wins, ABCD never shown.
    run_to(5, 1'b0);
    cycle(1'b1, 16'hABCD, 1'b0);
    repeat (3) cycle(1'b0, 16'h0, 1'b0);
    chk("pend_abcd", pend, 1'b1);
    cycle(1'b1, 16'h5678, 1'b0);
    for (int c = 0; c < 2 * FRAME; c++) begin
      cycle(1'b0, 16'h0, 1'b0);
      chk("no_abcd", nibble >= 4'hA, 1'b0);
    end
    chk("pend_cleared", pend, 1'b0);

    // Load on the boundary tick beats a pending 0000.
    run_to(3, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0);
    run_to(FRAME - 1, 1'b0);
    chk("pend_before_ovr", pend, 1'b1);
    cycle(1'b1, 16'hFFFF, 1'b0);
    chk("pend_after_ovr", pend, 1'b0);
    repeat (FRAME) cycle(1'b0, 16'h0, 1'b0);

    // Leading-zero suppression on 0020, then 0000.
    run_to(2, 1'b1);
    cycle(1'b1, 16'h0020, 1'b1);
    run_to(0, 1'b1);
    for (int d = 0; d < DIGITS; d++) act[d] = 0;
    for (int c = 0; c < FRAME; c++) begin
      cycle(1'b0, 16'h0, 1'b1);
      for (int d = 0; d < DIGITS; d++) if (an[d] == 1'b0) act[d]++;
    end
    chk("lz_d3", act[3], 0);
    chk("lz_d2", act[2], 0);
    chk("lz_d1", act[1], DIV - BLANK);
    chk("lz_d0", act[0], DIV - BLANK);
    cycle(1'b1, 16'h0000, 1'b1);
    run_to(0, 1'b1);
    repeat (FRAME) cycle(1'b0, 16'h0, 1'b1);

    // Reset mid-slot on digit 2 with a value pending.
    run_to(4, 1'b0);
    cycle(1'b1, 16'h9999, 1'b0);
    run_to(2 * DIV + 2, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_an", an, 4'hF);
    chk("midrst_pend", pend, 1'b0);
    chk("midrst_nibble", nibble, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      cycle(1'b0, 16'h0, 1'b0);
      if (frame) begin
        seen = 1'b1;
        chk("frame_after_rst", n, FRAME);
      end
    end
    chk("frame_seen", seen, 1'b1);

    // Random traffic.
    blz_r = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 15) == 0) blz_r = ~blz_r;
      cycle($urandom_range(0, 7) == 0, 16'($urandom), blz_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_scan.md
HEX_SCAN -- requirements
Module: hex_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed hex digits (2..8).
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot (>= 2).
REQ-003 Parameter BLANK, default 2: dead-time cycles at slot start with all anodes off (1..DIV-1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 value  input  4*DIGITS  hex value to show; digit i = value[4*i+3:4*i], digit 0 rightmost.
REQ-007 load  input  1  capture value this cycle (single-cycle strobe; held high = capture every cycle).
REQ-008 blank_lz  input  1  suppress leading zero digits.
REQ-009 nibble  output  4  current digit nibble, feeds the 7-segment decoder data input.
REQ-010 an  output  DIGITS  active-low anode enables; at most one bit low.
REQ-011 frame  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.
REQ-012 pend  output  1  high while a captured value waits for the next frame boundary.

Function
REQ-013 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0; the wrap cycle is the tick.
REQ-014 Digit index idx SHALL increment on each tick, wrapping DIGITS-1 -> 0.
REQ-015 Frame boundary = tick with idx == DIGITS-1; frame SHALL be high for exactly the following cycle.
REQ-016 The display SHALL read only a shadow register; value never drives nibble directly.
REQ-017 load with no boundary: pending <= value, pend <= 1; a later load overwrites pending (last wins).
REQ-018 At a boundary with pend=1 and load=0: shadow <= pending, pend <= 0.
REQ-019 At a boundary with load=1: shadow <= value directly, pend <= 0 (load has priority over pending).
REQ-020 Shadow SHALL change only at frame boundaries, so a frame never mixes old and new digits.
REQ-021 nibble and an SHALL be registered: both reflect the new idx in the cycle after the tick.
REQ-022 For cnt < BLANK in a slot, an SHALL be all ones; nibble SHALL already hold the slot's digit.
REQ-023 For cnt >= BLANK, an[idx] SHALL be 0, all other bits 1, unless the digit is suppressed.
REQ-024 Suppressed: blank_lz=1, idx != 0, and shadow digits DIGITS-1 down to idx all zero; an SHALL stay all ones for the slot.
REQ-025 Digit 0 SHALL never be suppressed (value 0 shows a single "0").
REQ-026 blank_lz SHALL be sampled every cycle; a change takes effect on the next cycle's an.
REQ-027 Scan timing SHALL be independent of load; loads never reset cnt or idx.

Reset
REQ-028 While rst=1: cnt=0, idx=0, shadow=0, pending=0, pend=0, nibble=0, an=all ones, frame=0.
REQ-029 Reset asserted mid-slot SHALL immediately force an to all ones; the scan restarts at digit 0 slot start after release.
REQ-030 First rising edge after release is cnt 0->1 of digit 0; an SHALL stay all ones for BLANK cycles.

Verification (DIGITS=4, DIV=4, BLANK=1 unless stated)
REQ-031 Release reset, load value=16'h1234 once -> after the first frame pulse, slots show nibbles 4,3,2,1 with an 1110,1101,1011,0111, each active 3 of 4 cycles after 1 dead cycle.
REQ-032 Load 16'hABCD mid-frame, then 16'h5678 before the boundary -> pend=1 until boundary, then shadow=16'h5678, ABCD never displayed, no frame mixes digits.
REQ-033 load=1 with value=16'hFFFF exactly on the boundary tick while pend=1 holding 16'h0000 -> shadow=16'hFFFF, pend=0.
REQ-034 blank_lz=1, shadow=16'h0020 -> digits 3,2 an all ones for entire slots; digits 1,0 enabled showing 2,0; shadow=16'h0000 -> only digit 0 enabled showing 0.
REQ-035 Assert rst for 1 cycle mid-slot on digit 2 -> an=1111 same cycle, shadow=0, next frame pulse exactly 16 cycles after release.
REQ-036 Over 1000 random cycles with random load/blank_lz, an SHALL never have more than one bit low.
